// File: rtl/ixu_encode.sv
// IXU re-encoder: decoded integer-ALU ops back to RV32I R/I-type words,
// buffered in a small FIFO and issued to the bundle's IXU slot.
module ixu_encode #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic             in_is_imm,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [11:0]      in_imm,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic             err_invalid,
  output logic [CNT_W-1:0] err_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic        full;
  logic        accept;
  logic        op_ok;
  logic        is_shift;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] enc;
  logic        push;
  logic        pop;

  always_comb begin
    funct3   = 3'd0;
    op_ok    = 1'b1;
    is_shift = 1'b0;
    unique case (in_op)
      4'd0: funct3 = 3'd0;
      4'd1: begin
        funct3 = 3'd0;
        op_ok  = !in_is_imm;
      end
      4'd2: funct3 = 3'd4;
      4'd3: funct3 = 3'd6;
      4'd4: funct3 = 3'd7;
      4'd5: begin
        funct3   = 3'd1;
        is_shift = 1'b1;
      end
      4'd6: begin
        funct3   = 3'd5;
        is_shift = 1'b1;
      end
      4'd7: begin
        funct3   = 3'd5;
        is_shift = 1'b1;
      end
      4'd8: funct3 = 3'd2;
      4'd9: funct3 = 3'd3;
      default: op_ok = 1'b0;
    endcase
  end

  assign funct7 = (in_op == 4'd1 || in_op == 4'd7)
                ? 7'h20 : 7'h00;

  always_comb begin
    enc = 32'h0;
    if (!in_is_imm)
      enc = {funct7, in_rs2, in_rs1, funct3, in_rd, OPC_R};
    else if (is_shift)
      enc = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, OPC_I};
    else
      enc = {in_imm, in_rs1, funct3, in_rd, OPC_I};
  end

  assign full      = (count == CW'(DEPTH));
  assign in_ready  = !full;
  assign out_valid = (count != '0);
  assign out_inst  = out_valid ? mem[rd_ptr] : 32'h0;

  assign accept = in_valid && in_ready;
  // flush wins over a same-cycle push or pop
  assign push   = accept && op_ok && !flush;
  assign pop    = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= enc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)
        count <= count + 1'b1;
      else if (pop && !push)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_invalid <= 1'b0;
      err_count   <= '0;
    end else begin
      err_invalid <= accept && !op_ok;
      if (accept && !op_ok && err_count != '1)
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_ixu_encode.sv
// Directed bench for ixu_encode: encodings, FIFO order/wrap,
// backpressure, invalid-op errors with saturation, flush and reset.
module tb_ixu_encode;

  localparam int DEPTH = 4;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_op;
  logic             in_is_imm;
  logic [4:0]       in_rd;
  logic [4:0]       in_rs1;
  logic [4:0]       in_rs2;
  logic [11:0]      in_imm;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_inst;
  logic             err_invalid;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  ixu_encode #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_op(in_op),
    .in_is_imm(in_is_imm),
    .in_rd(in_rd),
    .in_rs1(in_rs1),
    .in_rs2(in_rs2),
    .in_imm(in_imm),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst(out_inst),
    .err_invalid(err_invalid),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [3:0] op, input logic imm_f,
                        input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [11:0] imm);
    in_valid  = 1'b1;
    in_op     = op;
    in_is_imm = imm_f;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  task automatic push(input logic [3:0] op, input logic imm_f,
                      input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [11:0] imm);
    set_op(op, imm_f, rd, rs1, rs2, imm);
    step();
    in_valid = 1'b0;
  endtask

  logic [31:0] fill [4];

  initial begin
    fill[0] = 32'h000000B3;
    fill[1] = 32'h00000133;
    fill[2] = 32'h000001B3;
    fill[3] = 32'h00000233;

    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_is_imm = 1'b0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    flush = 1'b0; out_ready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_err_invalid", 32'(err_invalid), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);

    // back-to-back stream, pop and push in the same cycle
    push(4'd0, 1'b0, 5'd3, 5'd1, 5'd2, 12'h000);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add", out_inst, 32'h002081B3);
    push(4'd1, 1'b0, 5'd5, 5'd6, 5'd7, 12'h000);
    chk("sub", out_inst, 32'h407302B3);
    push(4'd0, 1'b1, 5'd1, 5'd0, 5'd0, 12'h005);
    chk("addi", out_inst, 32'h00500093);
    push(4'd7, 1'b1, 5'd2, 5'd2, 5'd0, 12'h003);
    chk("srai_3", out_inst, 32'h40315113);
    push(4'd7, 1'b1, 5'd2, 5'd2, 5'd0, 12'hFE3);
    chk("srai_fe3", out_inst, 32'h40315113);
    push(4'd3, 1'b0, 5'd4, 5'd5, 5'd6, 12'h000);
    chk("or", out_inst, 32'h0062E233);
    push(4'd9, 1'b1, 5'd7, 5'd8, 5'd0, 12'h7FF);
    chk("sltiu", out_inst, 32'h7FF43393);
    push(4'd5, 1'b1, 5'd1, 5'd1, 5'd0, 12'hFE5);
    chk("slli", out_inst, 32'h00509093);
    step();
    chk("idle_valid", 32'(out_valid), 32'd0);
    chk("idle_inst", out_inst, 32'h0);

    // fill under backpressure; write pointer wraps
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      push(4'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 12'h000);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head", out_inst, fill[0]);
    step();
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_head", out_inst, fill[0]);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain_%0d", i), out_inst, fill[i]);
      step();
    end
    chk("drained_valid", 32'(out_valid), 32'd0);
    chk("drained_ready", 32'(in_ready), 32'd1);

    // invalid ops and saturation of the 2-bit counter
    push(4'd12, 1'b0, 5'd1, 5'd1, 5'd1, 12'h000);
    chk("bad_op_pulse", 32'(err_invalid), 32'd1);
    chk("bad_op_count", 32'(err_count), 32'd1);
    chk("bad_op_noword", 32'(out_valid), 32'd0);
    push(4'd1, 1'b1, 5'd1, 5'd1, 5'd1, 12'h001);
    chk("subi_pulse", 32'(err_invalid), 32'd1);
    chk("subi_count", 32'(err_count), 32'd2);
    chk("subi_noword", 32'(out_valid), 32'd0);
    step();
    chk("pulse_end", 32'(err_invalid), 32'd0);
    push(4'd15, 1'b0, 5'd0, 5'd0, 5'd0, 12'h000);
    chk("count_max", 32'(err_count), 32'd3);
    push(4'd10, 1'b0, 5'd0, 5'd0, 5'd0, 12'h000);
    chk("count_sat", 32'(err_count), 32'd3);
    chk("sat_pulse", 32'(err_invalid), 32'd1);

    // flush with a same-cycle push
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      push(4'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 12'h000);
    chk("pre_flush_valid", 32'(out_valid), 32'd1);
    set_op(4'd2, 1'b0, 5'd9, 5'd9, 5'd9, 12'h000);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_inst", out_inst, 32'h0);
    chk("flush_ready", 32'(in_ready), 32'd1);
    chk("flush_no_err", 32'(err_invalid), 32'd0);
    step();
    chk("flush_stays_empty", 32'(out_valid), 32'd0);

    // reset mid-stream
    for (int i = 0; i < 3; i++)
      push(4'd0, 1'b0, 5'(i + 1), 5'd0, 5'd0, 12'h000);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_inst", out_inst, 32'h0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_count", 32'(err_count), 32'd0);
    out_ready = 1'b1;
    push(4'd0, 1'b0, 5'd3, 5'd1, 5'd2, 12'h000);
    chk("post_rst_add", out_inst, 32'h002081B3);
    step();
    chk("post_rst_empty", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
